// File: rtl/md_sequencer.sv
// Execute-stage controller for the shared multiply/divide unit: detects mul/div in X,
// issues the operation, stalls the front end and presents a single-cycle writeback.
module md_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_CYCLES = 40,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [31:0]           instruction_x,
    input  logic                  instr_valid_x,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] data_a,
    input  logic [DATA_WIDTH-1:0] data_b,
    input  logic                  md_ready,
    input  logic                  md_exception,
    input  logic [DATA_WIDTH-1:0] md_result,
    output logic                  md_start,
    output logic                  md_is_div,
    output logic [DATA_WIDTH-1:0] md_op_a,
    output logic [DATA_WIDTH-1:0] md_op_b,
    output logic                  stall,
    output logic                  wb_valid,
    output logic [4:0]            wb_reg,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic [1:0]            state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [CNT_WIDTH-1:0]  counter;
    logic [4:0]            rd_q;
    logic [DATA_WIDTH-1:0] result_q;
    logic                  exc_q;
    logic                  timeout_q;

    logic [4:0] op;
    logic [4:0] alu;
    logic [4:0] rd;
    logic       detect;
    logic       timeout_hit;
    logic       unused_instr_bits;

    assign op  = instruction_x[31:27];
    assign alu = instruction_x[6:2];
    assign rd  = instruction_x[26:22];
    assign unused_instr_bits = ^{instruction_x[21:7], instruction_x[1:0]};

    // Handshake: md_start is a one-cycle request; the unit answers later with md_ready,
    // which (with md_result/md_exception) is only honoured while BUSY.
    assign detect      = instr_valid_x & (op == 5'b00000)
                       & ((alu == 5'b00110) | (alu == 5'b00111)) & ~flush;
    assign timeout_hit = (counter == CNT_WIDTH'(MAX_CYCLES - 1));
    assign state_dbg   = state;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        stall      = 1'b0;
        wb_valid   = 1'b0;
        wb_reg     = 5'd0;
        wb_data    = '0;
        case (state)
            S_IDLE: begin
                stall = detect;
                if (detect) state_next = S_BUSY;
            end
            S_BUSY: begin
                stall = 1'b1;
                if (flush)            state_next = S_IDLE;
                else if (md_ready)    state_next = S_DONE;
                else if (timeout_hit) state_next = S_DONE;
            end
            S_DONE: begin
                state_next = S_IDLE;
                wb_valid   = ~flush;
                if (timeout_q) begin
                    wb_reg  = 5'd30;
                    wb_data = DATA_WIDTH'(7);
                end else if (exc_q) begin
                    wb_reg  = 5'd30;
                    wb_data = md_is_div ? DATA_WIDTH'(5) : DATA_WIDTH'(4);
                end else begin
                    wb_reg  = rd_q;
                    wb_data = result_q;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            counter   <= '0;
            md_start  <= 1'b0;
            md_is_div <= 1'b0;
            md_op_a   <= '0;
            md_op_b   <= '0;
            rd_q      <= 5'd0;
            result_q  <= '0;
            exc_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            md_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (detect) begin
                        md_op_a   <= data_a;
                        md_op_b   <= data_b;
                        md_is_div <= (alu == 5'b00111);
                        rd_q      <= rd;
                        counter   <= '0;
                        md_start  <= 1'b1;
                        exc_q     <= 1'b0;
                        timeout_q <= 1'b0;
                    end
                end
                S_BUSY: begin
                    counter <= counter + 1'b1;
                    // Flush wins over a same-cycle ready, which wins over timeout.
                    if (!flush) begin
                        if (md_ready) begin
                            result_q <= md_result;
                            exc_q    <= md_exception;
                        end else if (timeout_hit) begin
                            timeout_q <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_md_sequencer.sv
// Directed bench for md_sequencer: writebacks are predicted into a queue at issue
// time and popped by a negedge monitor whenever wb_valid is seen.
module tb_md_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instruction_x = '0;
    logic        instr_valid_x = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] data_a = '0;
    logic [31:0] data_b = '0;
    logic        md_ready = 1'b0;
    logic        md_exception = 1'b0;
    logic [31:0] md_result = '0;
    logic        md_start;
    logic        md_is_div;
    logic [31:0] md_op_a;
    logic [31:0] md_op_b;
    logic        stall;
    logic        wb_valid;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic [1:0]  state_dbg;

    int pass_cnt = 0;
    int total_cnt = 0;
    int start_cnt = 0;
    int stall_cnt = 0;
    int wb_cnt = 0;
    logic [36:0] exp_q[$];

    md_sequencer #(.DATA_WIDTH(32), .MAX_CYCLES(40), .CNT_WIDTH(6)) dut (
        .clock(clock), .reset(reset), .instruction_x(instruction_x),
        .instr_valid_x(instr_valid_x), .flush(flush), .data_a(data_a), .data_b(data_b),
        .md_ready(md_ready), .md_exception(md_exception), .md_result(md_result),
        .md_start(md_start), .md_is_div(md_is_div), .md_op_a(md_op_a), .md_op_b(md_op_b),
        .stall(stall), .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
        .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // scoreboard / monitor
    always @(negedge clock) begin
        if (!reset) begin
            if (md_start) start_cnt++;
            if (stall) stall_cnt++;
            if (wb_valid) begin
                wb_cnt++;
                if (exp_q.size() == 0) begin
                    check("wb_unexpected", {27'd0, wb_reg, wb_data}, 64'd0);
                end else begin
                    check("wb", {27'd0, wb_reg, wb_data}, {27'd0, exp_q.pop_front()});
                end
            end
        end
    end

    function automatic logic [31:0] mk(input logic [4:0] rd, input logic is_div);
        return {5'b00000, rd, 15'd0, (is_div ? 5'b00111 : 5'b00110), 2'b00};
    endfunction

    // drivers
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_counts();
        start_cnt = 0;
        stall_cnt = 0;
        wb_cnt = 0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic is_div,
                         input logic [31:0] a, input logic [31:0] b);
        tick();
        instruction_x = mk(rd, is_div);
        instr_valid_x = 1'b1;
        data_a = a;
        data_b = b;
        @(negedge clock);
        check("stall_detect", stall, 1);
    endtask

    task automatic run_op(input logic [4:0] rd, input logic is_div, input logic [31:0] a,
                          input logic [31:0] b, input int ready_at, input logic [31:0] result,
                          input logic exc, input logic [4:0] exp_reg,
                          input logic [31:0] exp_data, input int exp_stall);
        bit done = 0;
        clear_counts();
        exp_q.push_back({exp_reg, exp_data});
        issue(rd, is_div, a, b);
        for (int c = 1; c <= 100; c++) begin
            tick();
            md_ready = (c == ready_at);
            md_result = (c == ready_at) ? result : 32'd0;
            md_exception = (c == ready_at) & exc;
            @(negedge clock);
            if (c == 1) begin
                check("start_pulse", md_start, 1);
                check("op_a", md_op_a, a);
                check("op_b", md_op_b, b);
                check("is_div", md_is_div, is_div);
            end
            if (state_dbg == 2'd2) begin
                done = 1;
                break;
            end
        end
        check("done_reached", done, 1);
        check("done_stall", stall, 0);
        check("done_wb_valid", wb_valid, 1);
        tick();
        instr_valid_x = 1'b0;
        md_ready = 1'b0;
        @(negedge clock);
        check("back_idle", state_dbg, 0);
        check("start_count", start_cnt, 1);
        check("stall_count", stall_cnt, exp_stall);
        check("wb_count", wb_cnt, 1);
    endtask

    initial begin
        #2;
        check("rst_start", md_start, 0);
        check("rst_stall", stall, 0);
        check("rst_wb", {wb_valid, wb_reg, wb_data}, 0);
        check("rst_ops", {md_is_div, md_op_a, md_op_b}, 0);
        check("rst_state", state_dbg, 0);
        tick();
        reset = 1'b0;

        // mul 6*7 -> rd3, ready in BUSY cycle 4
        run_op(5'd3, 1'b0, 32'd6, 32'd7, 4, 32'd42, 1'b0, 5'd3, 32'd42, 5);
        // div by zero -> rstatus 5
        run_op(5'd5, 1'b1, 32'd9, 32'd0, 2, 32'hdead, 1'b1, 5'd30, 32'd5, 3);
        // mul overflow -> rstatus 4
        run_op(5'd7, 1'b0, 32'hffff_ffff, 32'h7fff_ffff, 2, 32'hbeef, 1'b1, 5'd30, 32'd4, 3);
        // unit never answers -> timeout after 40 BUSY cycles
        run_op(5'd9, 1'b0, $urandom_range(1, 1000), $urandom_range(1, 1000), 0, 32'd0,
               1'b0, 5'd30, 32'd7, 41);
        // rd = 0 is still written back
        run_op(5'd0, 1'b1, 32'd100, 32'd7, 1, 32'd14, 1'b0, 5'd0, 32'd14, 2);

        // flush in BUSY cycle 3
        clear_counts();
        issue(5'd11, 1'b0, 32'd3, 32'd4);
        tick();
        tick();
        tick();
        flush = 1'b1;
        @(negedge clock);
        check("flush_busy_stall", stall, 1);
        tick();
        flush = 1'b0;
        instr_valid_x = 1'b0;
        @(negedge clock);
        check("flush_idle", state_dbg, 0);
        check("flush_stall", stall, 0);
        tick();
        @(negedge clock);
        check("flush_no_wb", wb_cnt, 0);

        // flush together with detect
        clear_counts();
        tick();
        instruction_x = mk(5'd12, 1'b1);
        instr_valid_x = 1'b1;
        flush = 1'b1;
        @(negedge clock);
        check("flushdet_stall", stall, 0);
        tick();
        flush = 1'b0;
        instr_valid_x = 1'b0;
        @(negedge clock);
        check("flushdet_start", start_cnt, 0);
        check("flushdet_state", state_dbg, 0);

        // bubble with a stray md_ready in IDLE
        clear_counts();
        tick();
        instruction_x = mk(5'd13, 1'b0);
        instr_valid_x = 1'b0;
        md_ready = 1'b1;
        md_result = 32'd99;
        @(negedge clock);
        check("bubble_stall", stall, 0);
        tick();
        md_ready = 1'b0;
        @(negedge clock);
        check("bubble_start", start_cnt, 0);
        check("bubble_wb", wb_cnt, 0);

        // reset mid-BUSY
        clear_counts();
        issue(5'd4, 1'b1, 32'd11, 32'd12);
        tick();
        @(negedge clock);
        check("rstb_start", md_start, 1);
        check("rstb_div", md_is_div, 1);
        #2;
        reset = 1'b1;
        instr_valid_x = 1'b0;
        #1;
        check("rstb_start0", md_start, 0);
        check("rstb_stall0", stall, 0);
        check("rstb_ops0", {md_is_div, md_op_a, md_op_b}, 0);
        check("rstb_state0", state_dbg, 0);
        check("rstb_wb0", {wb_valid, wb_reg, wb_data}, 0);
        tick();
        reset = 1'b0;
        run_op(5'd4, 1'b0, 32'd11, 32'd12, 3, 32'd132, 1'b0, 5'd4, 32'd132, 4);

        // back-to-back muls, each answered in BUSY cycle 1
        clear_counts();
        exp_q.push_back({5'd1, 32'd6});
        exp_q.push_back({5'd2, 32'd20});
        issue(5'd1, 1'b0, 32'd2, 32'd3);
        tick();
        md_ready = 1'b1;
        md_result = 32'd6;
        @(negedge clock);
        check("b2b_start1", md_start, 1);
        tick();
        md_ready = 1'b0;
        @(negedge clock);
        check("b2b_done1", state_dbg, 2);
        tick();
        instruction_x = mk(5'd2, 1'b0);
        data_a = 32'd4;
        data_b = 32'd5;
        @(negedge clock);
        check("b2b_detect2", stall, 1);
        tick();
        md_ready = 1'b1;
        md_result = 32'd20;
        @(negedge clock);
        check("b2b_start2", md_start, 1);
        check("b2b_op_a2", md_op_a, 32'd4);
        tick();
        md_ready = 1'b0;
        @(negedge clock);
        check("b2b_done2", state_dbg, 2);
        tick();
        instr_valid_x = 1'b0;
        @(negedge clock);
        check("b2b_starts", start_cnt, 2);
        check("b2b_wbs", wb_cnt, 2);
        check("b2b_stalls", stall_cnt, 4);

        check("sb_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
